// File: rtl/eb_pack.sv
// rtl/eb_pack.sv - elastic word packer: groups up to N W-bit words into one N*W-bit beat
// A t_last word closes a partial group early; the beat sits in a registered req/ack initiator port.
module eb_pack #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   t_dat,
  input  logic           t_last,
  input  logic           t_req,
  output logic           t_ack,
  output logic [N*W-1:0] i_dat,
  output logic [N-1:0]   i_keep,
  output logic           i_last,
  output logic           i_req,
  input  logic           i_ack
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_LANE = CW'(N - 1);

  logic [(N-1)*W-1:0] acc;
  logic [N*W-1:0]     acc_ext;
  logic [CW-1:0]      cnt;
  logic               t_xfer;
  logic               i_xfer;
  logic               close;
  logic [N*W-1:0]     beat_dat;
  logic [N-1:0]       beat_keep;

  // The only combinational path through the block: i_ack -> t_ack.
  assign t_ack   = ~i_req | i_ack;
  assign t_xfer  = t_req & t_ack;
  assign i_xfer  = i_req & i_ack;
  assign close   = t_xfer & (t_last | (cnt == LAST_LANE));
  assign acc_ext = {{W{1'b0}}, acc};

  // Beat formed from the accumulated lanes plus the closing word in lane cnt.
  always_comb begin
    beat_dat  = '0;
    beat_keep = '0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(cnt)) begin
        beat_dat[k*W +: W] = acc_ext[k*W +: W];
      end else if (k == int'(cnt)) begin
        beat_dat[k*W +: W] = t_dat;
      end
      beat_keep[k] = (k <= int'(cnt));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      i_dat  <= '0;
      i_keep <= '0;
      i_last <= 1'b0;
      i_req  <= 1'b0;
    end else begin
      if (i_xfer) begin
        i_dat  <= '0;
        i_keep <= '0;
        i_last <= 1'b0;
        i_req  <= 1'b0;
      end
      // A same-edge close overrides the drain above, so back-to-back beats keep i_req high.
      if (close) begin
        i_dat  <= beat_dat;
        i_keep <= beat_keep;
        i_last <= t_last;
        i_req  <= 1'b1;
        cnt    <= '0;
        acc    <= '0;
      end else if (t_xfer) begin
        for (int k = 0; k < N - 1; k++) begin
          if (k == int'(cnt)) acc[k*W +: W] <= t_dat;
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eb_pack.sv
// tb/tb_eb_pack.sv - self-checking bench for eb_pack
// Directed cases plus randomized traffic against a queue-based reference model.
module tb_eb_pack;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic [W-1:0]   t_dat;
  logic           t_last;
  logic           t_req;
  logic           t_ack;
  logic [N*W-1:0] i_dat;
  logic [N-1:0]   i_keep;
  logic           i_last;
  logic           i_req;
  logic           i_ack;

  int checks = 0;
  int passed = 0;

  // Reference model: words of the open group, and the beat currently offered downstream.
  logic [W-1:0]   mq[$];
  logic           m_req;
  logic [N*W-1:0] m_dat;
  logic [N-1:0]   m_keep;
  logic           m_last;

  eb_pack #(.W(W), .N(N)) dut (
    .clk(clk), .reset(reset),
    .t_dat(t_dat), .t_last(t_last), .t_req(t_req), .t_ack(t_ack),
    .i_dat(i_dat), .i_keep(i_keep), .i_last(i_last), .i_req(i_req), .i_ack(i_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, updating the model from the inputs applied at that edge.
  task automatic tick();
    logic etack, tx, ix;
    @(posedge clk);
    etack = !m_req || i_ack;
    tx = t_req && etack;
    ix = m_req && i_ack;
    if (reset) begin
      mq.delete();
      m_req = 0; m_dat = '0; m_keep = '0; m_last = 0;
    end else begin
      if (ix) begin
        m_req = 0; m_dat = '0; m_keep = '0; m_last = 0;
      end
      if (tx) begin
        mq.push_back(t_dat);
        if (t_last || mq.size() == N) begin
          m_dat = '0;
          foreach (mq[i]) m_dat[i*W +: W] = mq[i];
          m_keep = N'((1 << mq.size()) - 1);
          m_last = t_last;
          m_req = 1;
          mq.delete();
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; t_req = 0; t_last = 0; t_dat = '0; i_ack = 0;
    tick(); tick();
    reset = 0;
    @(negedge clk);
    checks++; if (i_req !== 1'b0) $display("FAIL rst_req got %0h want 0", i_req); else passed++;
    checks++; if (t_ack !== 1'b1) $display("FAIL rst_tack got %0h want 1", t_ack); else passed++;
    checks++; if (i_dat !== '0) $display("FAIL rst_dat got %0h want 0", i_dat); else passed++;
    checks++; if (i_keep !== 4'b0000) $display("FAIL rst_keep got %0b want 0000", i_keep); else passed++;
    checks++; if (i_last !== 1'b0) $display("FAIL rst_last got %0h want 0", i_last); else passed++;
    tick();
  endtask

  task automatic test_full_group();
    i_ack = 1;
    for (int w = 1; w <= 4; w++) begin
      t_req = 1; t_dat = W'(w); t_last = 0;
      tick();
    end
    t_req = 0;
    @(negedge clk);
    checks++; if (i_dat !== 128'h00000004_00000003_00000002_00000001)
      $display("FAIL full_dat got %h want 00000004000000030000000200000001", i_dat); else passed++;
    checks++; if (i_keep !== 4'b1111) $display("FAIL full_keep got %0b want 1111", i_keep); else passed++;
    checks++; if (i_last !== 1'b0) $display("FAIL full_last got %0h want 0", i_last); else passed++;
    checks++; if (i_req !== 1'b1) $display("FAIL full_req got %0h want 1", i_req); else passed++;
    tick();
    @(negedge clk);
    checks++; if (i_req !== 1'b0) $display("FAIL full_req_pulse got %0h want 0", i_req); else passed++;
  endtask

  task automatic test_partial();
    i_ack = 1;
    t_req = 1; t_dat = 32'hA; t_last = 0; tick();
    t_dat = 32'hB; t_last = 1; tick();
    t_req = 0; t_last = 0;
    @(negedge clk);
    checks++; if (i_dat !== 128'h0000000B_0000000A) $display("FAIL part_dat got %h want ...0000000b0000000a", i_dat); else passed++;
    checks++; if (i_keep !== 4'b0011) $display("FAIL part_keep got %0b want 0011", i_keep); else passed++;
    checks++; if (i_last !== 1'b1) $display("FAIL part_last got %0h want 1", i_last); else passed++;
    // Next word must start a fresh group in lane 0, replacing the beat on the same edge.
    t_req = 1; t_dat = 32'hC; t_last = 1; tick();
    t_req = 0; t_last = 0;
    @(negedge clk);
    checks++; if (i_dat !== 128'h0000000C) $display("FAIL part_next_dat got %h want ...0000000c", i_dat); else passed++;
    checks++; if (i_keep !== 4'b0001) $display("FAIL part_next_keep got %0b want 0001", i_keep); else passed++;
    tick();
  endtask

  task automatic test_first_last();
    i_ack = 1;
    t_req = 1; t_dat = 32'h55; t_last = 1; tick();
    t_req = 0; t_last = 0;
    @(negedge clk);
    checks++; if (i_dat !== 128'h55) $display("FAIL first_dat got %h want ...00000055", i_dat); else passed++;
    checks++; if (i_keep !== 4'b0001) $display("FAIL first_keep got %0b want 0001", i_keep); else passed++;
    checks++; if (i_last !== 1'b1) $display("FAIL first_last got %0h want 1", i_last); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] got[$];
    logic [N*W-1:0] want[3];
    int w;
    logic acc;
    want[0] = 128'h00000004_00000003_00000002_00000001;
    want[1] = 128'h00000008_00000007_00000006_00000005;
    want[2] = 128'h0000000C_0000000B_0000000A_00000009;
    i_ack = 0;
    for (int k = 1; k <= 4; k++) begin
      t_req = 1; t_dat = W'(k); t_last = 0; tick();
    end
    t_dat = 32'd5;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (t_ack !== 1'b0) $display("FAIL bp_tack c%0d got %0h want 0", c, t_ack); else passed++;
      checks++; if (i_dat !== want[0]) $display("FAIL bp_hold c%0d got %h want %h", c, i_dat, want[0]); else passed++;
      tick();
    end
    i_ack = 1;
    w = 5;
    for (int c = 0; c < 40 && got.size() < 3; c++) begin
      @(negedge clk);
      if (i_req && i_ack) got.push_back(i_dat);
      acc = t_req && t_ack;
      tick();
      if (acc) begin
        w++;
        t_dat = W'(w);
        if (w > 12) t_req = 0;
      end
    end
    t_req = 0;
    checks++; if (got.size() != 3) $display("FAIL bp_count got %0d want 3", got.size()); else passed++;
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) begin
        checks++; if (got[k] !== want[k]) $display("FAIL bp_beat%0d got %h want %h", k, got[k], want[k]); else passed++;
      end
    end
    tick();
  endtask

  task automatic test_stream();
    int req_cycles = 0;
    int full_beats = 0;
    i_ack = 1;
    for (int w = 1; w <= 8; w++) begin
      t_req = 1; t_dat = W'(w); t_last = 0;
      @(negedge clk);
      checks++; if (t_ack !== 1'b1) $display("FAIL stream_tack w%0d got %0h want 1", w, t_ack); else passed++;
      if (i_req) begin
        req_cycles++;
        if (i_keep == 4'b1111) full_beats++;
      end
      tick();
    end
    t_req = 0;
    @(negedge clk);
    if (i_req) begin
      req_cycles++;
      if (i_keep == 4'b1111) full_beats++;
    end
    checks++; if (i_dat !== 128'h00000008_00000007_00000006_00000005)
      $display("FAIL stream_dat2 got %h want 00000008000000070000000600000005", i_dat); else passed++;
    checks++; if (req_cycles != 2) $display("FAIL stream_req_cycles got %0d want 2", req_cycles); else passed++;
    checks++; if (full_beats != 2) $display("FAIL stream_full_beats got %0d want 2", full_beats); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    i_ack = 1;
    t_req = 1; t_last = 0;
    t_dat = 32'h77; tick();
    t_dat = 32'h78; tick();
    t_req = 0; reset = 1; tick();
    reset = 0;
    @(negedge clk);
    checks++; if (i_req !== 1'b0) $display("FAIL mid_req got %0h want 0", i_req); else passed++;
    checks++; if (t_ack !== 1'b1) $display("FAIL mid_tack got %0h want 1", t_ack); else passed++;
    checks++; if (i_dat !== '0) $display("FAIL mid_dat got %h want 0", i_dat); else passed++;
    checks++; if (i_keep !== 4'b0000) $display("FAIL mid_keep got %0b want 0000", i_keep); else passed++;
    checks++; if (i_last !== 1'b0) $display("FAIL mid_last got %0h want 0", i_last); else passed++;
    for (int w = 0; w < 4; w++) begin
      t_req = 1; t_dat = 32'h21 + W'(w); tick();
    end
    t_req = 0;
    @(negedge clk);
    checks++; if (i_dat !== 128'h00000024_00000023_00000022_00000021)
      $display("FAIL mid_beat got %h want 00000024000000230000002200000021", i_dat); else passed++;
    checks++; if (i_keep !== 4'b1111) $display("FAIL mid_beat_keep got %0b want 1111", i_keep); else passed++;
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 600; c++) begin
      t_req  = ($urandom_range(0, 3) != 0);
      t_last = ($urandom_range(0, 4) == 0);
      t_dat  = $urandom;
      i_ack  = ($urandom_range(0, 2) != 0);
      reset  = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      if (!reset) begin
        checks++;
        if (t_ack !== (!m_req || i_ack) || i_req !== m_req || i_dat !== m_dat ||
            i_keep !== m_keep || i_last !== m_last) begin
          if (bad < 5)
            $display("FAIL rand c%0d got ack=%0h req=%0h keep=%0b last=%0h dat=%h want req=%0h keep=%0b last=%0h dat=%h",
                     c, t_ack, i_req, i_keep, i_last, i_dat, m_req, m_keep, m_last, m_dat);
          bad++;
        end else passed++;
      end
      tick();
    end
    reset = 0; t_req = 0; i_ack = 1;
    tick(); tick();
  endtask

  initial begin
    reset = 1; t_req = 0; t_last = 0; t_dat = '0; i_ack = 0;
    m_req = 0; m_dat = '0; m_keep = '0; m_last = 0;
    test_reset();
    test_full_group();
    test_partial();
    test_first_last();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
